// File: rtl/status_packet_tx.sv
// Byte-serial status packet transmitter: address, {seq, status[25:24]}, then PAYLOAD_BYTES payload bytes.
// Optional REQ watchdog enabled by defining STATUS_PACKET_TX_WATCHDOG_EN.
module status_packet_tx #(
  parameter logic [7:0]  STATUS_REG_ADDR = 8'h00,
  parameter int unsigned PAYLOAD_BYTES   = 3,
  parameter int          WD_CYCLES       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_we,
  input  logic [7:0]  ctrl_data,
  input  logic [25:0] status,
  output logic [7:0]  ad,
  output logic        rq,
  input  logic        start,
  output logic        busy,
  output logic        sent,
  output logic        wd_err
);

  typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

  localparam logic [2:0]  LAST_BYTE = 3'(PAYLOAD_BYTES + 1);
  localparam logic [23:0] PAY_MASK  = 24'((32'd1 << (8 * PAYLOAD_BYTES)) - 32'd1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [5:0]  seq_q, seq_d;
  logic        pend_q, pend_d;
  logic [5:0]  snap_seq_q, snap_seq_d;
  logic [25:0] snap_status_q, snap_status_d;
  logic [7:0]  ad_q, ad_d;
  logic        rq_q, rq_d;
  logic        busy_q, busy_d;
  logic        sent_q, sent_d;
  logic        launch;
  logic        changed;
  logic        wd_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mode_q        <= '0;
      seq_q         <= '0;
      pend_q        <= 1'b0;
      snap_seq_q    <= '0;
      snap_status_q <= '0;
      ad_q          <= '0;
      rq_q          <= 1'b0;
      busy_q        <= 1'b0;
      sent_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      seq_q         <= seq_d;
      pend_q        <= pend_d;
      snap_seq_q    <= snap_seq_d;
      snap_status_q <= snap_status_d;
      ad_q          <= ad_d;
      rq_q          <= rq_d;
      busy_q        <= busy_d;
      sent_q        <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (pend_q) state_d = REQ;
      REQ: begin
        if (start) begin
          state_d = SEND;
          cnt_d   = 3'd1;
        end else if (wd_timeout) begin
          state_d = GAP;
        end
      end
      SEND: begin
        if (cnt_q == LAST_BYTE) state_d = GAP;
        else                    cnt_d   = cnt_q + 3'd1;
      end
      GAP:     state_d = pend_q ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign launch = (state_d == REQ) && (state_q != REQ);

  // Change detection runs against the post-launch snapshot so a same-cycle event is re-evaluated, not dropped.
  always_comb begin
    mode_d        = mode_q;
    seq_d         = seq_q;
    pend_d        = pend_q;
    snap_seq_d    = snap_seq_q;
    snap_status_d = snap_status_q;
    if (launch) begin
      snap_seq_d    = seq_q;
      snap_status_d = status;
      pend_d        = 1'b0;
    end
    changed = (status[25:24] != snap_status_d[25:24]) ||
              (((status[23:0] ^ snap_status_d[23:0]) & PAY_MASK) != '0);
    if ((mode_q == 2'd3) && changed) pend_d = 1'b1;
    if (wd_timeout) pend_d = 1'b1;
    if (ctrl_we) begin
      mode_d = (ctrl_data[1:0] == 2'd2) ? 2'd0 : ctrl_data[1:0];
      seq_d  = ctrl_data[7:2];
      pend_d = ctrl_data[0];
    end
  end

  always_comb begin
    rq_d   = (state_d == REQ) || (state_d == SEND);
    busy_d = (state_d != IDLE);
    sent_d = (state_d == GAP) && (state_q == SEND);
    ad_d   = '0;
    case (state_d)
      REQ: ad_d = STATUS_REG_ADDR;
      SEND: begin
        case (cnt_d)
          3'd1:    ad_d = {snap_seq_q, snap_status_q[25:24]};
          3'd2:    ad_d = snap_status_q[7:0];
          3'd3:    ad_d = snap_status_q[15:8];
          default: ad_d = snap_status_q[23:16];
        endcase
      end
      default: ad_d = '0;
    endcase
  end

  assign ad   = ad_q;
  assign rq   = rq_q;
  assign busy = busy_q;
  assign sent = sent_q;

`ifdef STATUS_PACKET_TX_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WD_CYCLES + 1);

  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_err_q, wd_err_d;

  assign wd_timeout = (state_q == REQ) && !start && (wd_cnt_q == WDW'(WD_CYCLES - 1));

  always_comb begin
    wd_cnt_d = (state_q == REQ) ? wd_cnt_q + 1'b1 : '0;
    wd_err_d = wd_err_q;
    if (ctrl_we)    wd_err_d = 1'b0;
    if (wd_timeout) wd_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_timeout = 1'b0;
  // Always 0: WD_CYCLES is non-negative.
  assign wd_err     = (WD_CYCLES < 0);
`endif

endmodule

// File: tb/tb_status_packet_tx.sv
// Directed self-checking bench for status_packet_tx (PAYLOAD_BYTES=3 and PAYLOAD_BYTES=0 instances).
module tb_status_packet_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_we, ctrl_we0;
  logic [7:0]  ctrl_data, ctrl_data0;
  logic [25:0] status, status0;
  logic [7:0]  ad, ad0;
  logic        rq, rq0, busy, busy0, sent, sent0, wd_err, wd_err0;
  logic        start, start0;
  logic        rq_q = 1'b0, rq0_q = 1'b0;
  logic        start_ovr_en, start_ovr;
  int unsigned n_vec = 0, n_err = 0;
  logic [7:0]  pkt [5];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rq_q  <= rq;
    rq0_q <= rq0;
  end

  assign start  = start_ovr_en ? start_ovr : (rq && !rq_q);
  assign start0 = rq0 && !rq0_q;

  status_packet_tx #(.STATUS_REG_ADDR(8'h21), .PAYLOAD_BYTES(3), .WD_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .ctrl_we(ctrl_we), .ctrl_data(ctrl_data), .status(status),
    .ad(ad), .rq(rq), .start(start), .busy(busy), .sent(sent), .wd_err(wd_err)
  );

  status_packet_tx #(.STATUS_REG_ADDR(8'h21), .PAYLOAD_BYTES(0), .WD_CYCLES(10)) dut0 (
    .clk(clk), .rst(rst), .ctrl_we(ctrl_we0), .ctrl_data(ctrl_data0), .status(status0),
    .ad(ad0), .rq(rq0), .start(start0), .busy(busy0), .sent(sent0), .wd_err(wd_err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Checks n bytes on consecutive cycles starting at the current negedge, then the GAP cycle.
  task automatic expect_pkt(input string tag, input logic [7:0] exp [5], input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, "_rq"}, rq, 1);
      check({tag, "_ad"}, ad, exp[i]);
      @(negedge clk);
    end
    check({tag, "_gap_rq"}, rq, 0);
    check({tag, "_gap_ad"}, ad, 0);
    check({tag, "_sent"}, sent, 1);
  endtask

  // Auto-mode vectors for dut0 at negedges t0..t10 (status[25:24] set to (i+1)%4 after each check).
  logic [7:0] tab_ad   [11] = '{8'h00, 8'h00, 8'h21, 8'h0E, 8'h00, 8'h21, 8'h0D, 8'h00, 8'h21, 8'h0C, 8'h00};
  logic       tab_rq   [11] = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
  logic       tab_sent [11] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    rst = 1'b0;
    ctrl_we = 1'b0; ctrl_data = '0; status = '0;
    ctrl_we0 = 1'b0; ctrl_data0 = '0; status0 = '0;
    start_ovr_en = 1'b0; start_ovr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rq", rq, 0);
    check("rst_ad", ad, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent, 0);
    check("rst_wd_err", wd_err, 0);
    check("rst_rq0", rq0, 0);
    check("rst_wd_err0", wd_err0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_rq", rq, 0);

    // single shot, direct ack
    status = 26'h2ABCDEF; ctrl_data = 8'h55; ctrl_we = 1'b1;
    @(negedge clk);
    ctrl_we = 1'b0;
    check("t1_lat_rq", rq, 0);
    check("t1_lat_busy", busy, 0);
    @(negedge clk);
    pkt = '{8'h21, 8'h56, 8'hEF, 8'hCD, 8'hAB};
    expect_pkt("t1", pkt, 5);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_once_rq", rq, 0);
      check("t1_once_busy", busy, 0);
      check("t1_once_sent", sent, 0);
    end

    // delayed start: byte 0 held 8 cycles
    start_ovr_en = 1'b1; start_ovr = 1'b0;
    status = 26'h1123456; ctrl_data = 8'h55; ctrl_we = 1'b1;
    @(negedge clk);
    ctrl_we = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      check("t2_hold_rq", rq, 1);
      check("t2_hold_ad", ad, 8'h21);
      if (i == 7) start_ovr = 1'b1;
      @(negedge clk);
    end
    start_ovr = 1'b0;
    pkt = '{8'h55, 8'h56, 8'h34, 8'h12, 8'h00};
    expect_pkt("t2", pkt, 4);
    start_ovr_en = 1'b0;
    @(negedge clk);
    check("t2_idle", busy, 0);

    // control write mid-packet only affects the next packet
    status = 26'h2ABCDEF; ctrl_data = 8'h55; ctrl_we = 1'b1;
    @(negedge clk);
    ctrl_we = 1'b0;
    @(negedge clk);
    pkt = '{8'h21, 8'h56, 8'hEF, 8'hCD, 8'hAB};
    for (int unsigned i = 0; i < 5; i++) begin
      check("t4_a_rq", rq, 1);
      check("t4_a_ad", ad, pkt[i]);
      if (i == 2) begin ctrl_data = 8'h15; ctrl_we = 1'b1; end
      @(negedge clk);
      ctrl_we = 1'b0;
    end
    check("t4_gap_rq", rq, 0);
    check("t4_gap_sent", sent, 1);
    @(negedge clk);
    pkt = '{8'h21, 8'h16, 8'hEF, 8'hCD, 8'hAB};
    expect_pkt("t4_b", pkt, 5);
    repeat (2) @(negedge clk);
    check("t4_noarm", busy, 0);

    // reset during byte 2
    ctrl_data = 8'h55; ctrl_we = 1'b1;
    @(negedge clk);
    ctrl_we = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_pre_ad", ad, 8'hEF);
    #2 rst = 1'b0;
    #1;
    check("t5_async_rq", rq, 0);
    check("t5_async_ad", ad, 0);
    check("t5_async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_quiet_rq", rq, 0);
      check("t5_quiet_busy", busy, 0);
    end

    // auto mode, PAYLOAD_BYTES=0
    ctrl_data0 = 8'h0F; status0 = '0; ctrl_we0 = 1'b1;
    @(negedge clk);
    ctrl_we0 = 1'b0;
    @(negedge clk);
    check("t3_p0_rq", rq0, 1);
    check("t3_p0_ad", ad0, 8'h21);
    @(negedge clk);
    check("t3_p1_ad", ad0, 8'h0C);
    @(negedge clk);
    check("t3_gap_rq", rq0, 0);
    check("t3_gap_sent", sent0, 1);
    @(negedge clk);
    check("t3_idle", busy0, 0);
    status0[0] = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_bit0_rq", rq0, 0);
      check("t3_bit0_busy", busy0, 0);
    end
    for (int unsigned i = 0; i < 11; i++) begin
      @(negedge clk);
      check("t3_b2b_rq", rq0, tab_rq[i]);
      check("t3_b2b_ad", ad0, tab_ad[i]);
      check("t3_b2b_sent", sent0, tab_sent[i]);
      status0[25:24] = 2'((i + 1) % 4);
    end
    repeat (8) @(negedge clk);
    check("t3_settle", busy0, 0);

`ifdef STATUS_PACKET_TX_WATCHDOG_EN
    start_ovr_en = 1'b1; start_ovr = 1'b0;
    status = 26'h2ABCDEF; ctrl_data = 8'h55; ctrl_we = 1'b1;
    @(negedge clk);
    ctrl_we = 1'b0;
    check("t6_lat_rq", rq, 0);
    @(negedge clk);
    for (int unsigned i = 0; i < 10; i++) begin
      check("t6_req_rq", rq, 1);
      check("t6_req_ad", ad, 8'h21);
      @(negedge clk);
    end
    check("t6_to_rq", rq, 0);
    check("t6_to_err", wd_err, 1);
    check("t6_to_sent", sent, 0);
    @(negedge clk);
    check("t6_rereq_rq", rq, 1);
    check("t6_rereq_err", wd_err, 1);
    ctrl_data = 8'h00; ctrl_we = 1'b1; start_ovr = 1'b1;
    @(negedge clk);
    ctrl_we = 1'b0; start_ovr = 1'b0;
    check("t6_clr_err", wd_err, 0);
    pkt = '{8'h56, 8'hEF, 8'hCD, 8'hAB, 8'h00};
    expect_pkt("t6", pkt, 4);
    start_ovr_en = 1'b0;
    @(negedge clk);
    check("t6_idle", busy, 0);
`else
    check("wd_err_off", wd_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/status_packet_tx.md
# status_packet_tx

Subsystem-side transmitter for the byte-serial status channel: it formats a subsystem's status word as a 2- to 5-byte packet and drives it onto the shared `ad`/`rq` link. Packet order is address, then {sequence, 2 status bits}, then payload bytes. The central status receiver, directly or through the status router, stores the packet in AXI-readable status memory. One instance sits in each subsystem that reports status (sequencers, channels, sensors). Transmission is triggered by a control-word write (single shot) or, in auto mode, by any change of the status input.

## Interface
Parameters:
- `STATUS_REG_ADDR`, 8'h00: byte 0 of every packet, the status memory cell address.
- `PAYLOAD_BYTES`, 3: number of payload bytes after byte 1, legal range 0..3. Packet length is 2+`PAYLOAD_BYTES`.
- `WD_CYCLES`, 255: watchdog limit, used only with the configuration macro.

Ports:
- `clk` input 1: the only clock.
- `rst` input 1: reset, asynchronous and **active-low**.
- `ctrl_we` input 1: control write strobe.
- `ctrl_data` input 8: bits [1:0] are the mode (0 off, 1 single, 2 reserved and treated as 0, 3 auto); bits [7:2] are the sequence number.
- `status` input 26: bits [25:24] go in byte 1; bits [23:0] are the payload.
- `ad` output 8: byte-serial packet data.
- `rq` output 1: packet in progress.
- `start` input 1: acknowledge of byte 0 from the receiver or router.
- `busy` output 1: FSM is not IDLE.
- `sent` output 1: one-cycle pulse after the last byte of a packet.
- `wd_err` output 1: sticky watchdog error; tied to 0 without the macro.

## Operation
Control path:
- `ctrl_we` loads `mode` and `seq` from `ctrl_data`.
- If the new mode is 1 or 3, `pend` is set.
- A write with mode 0 clears `pend`. It does not abort a packet already in flight.

Auto mode (mode 3):
- `pend` is set in any cycle where `status[25:24]` differs from the snapshot, or where `status[8*PAYLOAD_BYTES-1:0]` differs from the snapshot.
- Bits that are not transmitted are ignored in this comparison.

FSM states: IDLE, REQ, SEND, GAP.
- IDLE → REQ when `pend`.
  - On this transition, capture the snapshot {`seq`, `status`} and clear `pend`.
  - A `pend` event in the same cycle as the transition is not lost: it is recomputed against the new snapshot.
- REQ:
  - `rq`=1, `ad`=`STATUS_REG_ADDR`.
  - Held until `start`=1 is sampled, then go to SEND with the byte counter at 1.
- SEND: `rq`=1, and `ad` carries one byte per cycle:
  - byte 1 = {snap_seq[5:0], snap_status[25:24]}
  - byte 2 = snap_status[7:0]
  - byte 3 = snap_status[15:8]
  - byte 4 = snap_status[23:16]
  - Transmission stops after byte 1+`PAYLOAD_BYTES`, then go to GAP.
  - `start` is ignored in SEND.
- GAP:
  - `rq`=0, `ad`=0, `sent`=1 for this cycle.
  - Always lasts exactly one cycle, then go to IDLE, or directly to REQ if `pend` is set.

Other rules:
- Mode 1 does not re-arm after a packet. A new write is needed for the next packet.
- Status or control changes during REQ/SEND affect only the next packet.
- The receiver stores byte 1 bits [7:2] as status bits 31:26, and bytes 2..4 as status bits 7:0, 15:8 and 23:16 in order.

## Timing
- All outputs are registered.
- Reset values: `rq`=0, `ad`=0, `busy`=0, `sent`=0, `wd_err`=0, `mode`=0, `seq`=0, `pend`=0, snapshot=0, FSM=IDLE.
- Reset asserted mid-packet drops `rq` asynchronously. The receiver sees a truncated packet, which is acceptable.
- Trigger latency:
  - `ctrl_we` at edge k sets `pend` at k. FSM enters REQ at edge k+1, so `rq` and byte 0 are visible after k+1.
  - In auto mode, a status change visible before edge k gives `rq` high after edge k+1.
- With the receiver connected directly, `start` is high in the first REQ cycle. `rq` then stays high for exactly 2+`PAYLOAD_BYTES` cycles, byte n appearing in cycle n.
- If `start` is delayed, byte 0 is held for as long as needed. Byte 1 follows on the cycle after the cycle in which `start`=1.
- Minimum `rq`-low time between packets is 1 cycle.

## Configuration
`STATUS_PACKET_TX_WATCHDOG_EN`:
- When defined:
  - An 8-bit counter (width fits `WD_CYCLES`) runs while in REQ.
  - If `start` has not arrived after `WD_CYCLES` cycles, the FSM goes to GAP with `rq`=0 and no `sent` pulse, sets `wd_err`, and sets `pend` again.
  - `wd_err` is cleared only by a `ctrl_we` write.
- When undefined:
  - REQ waits indefinitely.
  - No counter is built.
  - `wd_err` is a constant 0.

## Test plan
1. **Single shot, direct ack.** `PAYLOAD_BYTES`=3, addr 8'h21, write `ctrl_data`=8'h55 (seq 21, mode 1), `status`=26'h2ABCDEF, `start`=rq&&!rq_d. Required: `ad` = 21, 56, EF, CD, AB on 5 consecutive `rq`-high cycles, then `rq`=0 with `sent`=1. Exactly one packet.
2. **Delayed start.** Hold `start`=0 for 7 cycles in REQ. Required: `ad`=8'h21 steady for 8 cycles, then the bytes follow with no gaps.
3. **Auto mode, back-to-back.** `PAYLOAD_BYTES`=0, mode 3; change `status[25:24]` on every cycle, and separately change `status[0]`. Required: 2-byte packets with one `rq`-low cycle between them. Changing `status[0]` alone causes no packet.
4. **Mid-packet control write.** Write seq 5 during SEND. Required: the current packet keeps the old seq; the next packet carries seq 5 in byte 1 bits [7:2].
5. **Reset mid-packet.** Assert `rst` low during byte 2. Required: `rq`, `ad`, `busy` go to 0 immediately. No packet is sent after release until a new write.
6. **Watchdog** (macro defined). `WD_CYCLES`=10, `start` held 0. Required: `rq` drops after 10 REQ cycles, `wd_err`=1, and REQ is re-entered after 1 low cycle. A write clears `wd_err`.
